regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Hazard scoreboard that sequences instruction issue into the pipelined datapath so that no instruction reads a register-file operand while an older write to it is still in flight. Every accepted instruction that writes a register is tracked with a per-register outstanding-write counter. Each writeback to the register file releases one write. Issue is stalled on read-after-write hazards and on counter saturation. The block sits between decode/issue and the register file, alongside the writeback stage.

## Interface
Parameters:
- NREGS, 32, number of architectural registers; register 0 is hardwired and never tracked
- AW, 5, register index width (log2 NREGS)
- CW, 2, width of each per-register outstanding-write counter; maximum count is 2^CW-1

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst_n  input  1  asynchronous, active-low reset
- issue_valid  input  1  decode presents an instruction this cycle
- issue_rs1  input  AW  source register 1
- issue_rs2  input  AW  source register 2
- issue_use_rs2  input  1  instruction reads rs2
- issue_wr  input  1  instruction writes a destination register
- issue_rd  input  AW  destination register
- stall  output  1  combinational; instruction must be held and must not be issued this cycle
- issue_fire  output  1  combinational; equals issue_valid & !stall
- wb_valid  input  1  writeback stage writes the register file this cycle (regwrite)
- wb_rd  input  AW  writeback destination
- flush  input  1  synchronous; discard all in-flight tracking
- busy  output  1  registered; 1 when any counter is non-zero
- outstanding  output  AW+CW  registered; sum of all counters
- err_underflow  output  1  registered and sticky; a writeback arrived for an untracked register

## Operation
- State per register r = 1..NREGS-1: cnt[r], CW bits. cnt[0] is constant 0.
- Release term: rel[r] = wb_valid & (wb_rd == r) & (r != 0).
- Effective pending: pend[r] = (cnt[r] > 1) | (cnt[r] == 1 & !rel[r]).
  - A last in-flight write that commits this cycle does not block.
  - The register file writes on negedge and reads on the following posedge, so the value is valid for the issuing instruction.
- stall = issue_valid & (pend[rs1] | (issue_use_rs2 & pend[rs2]) | (issue_wr & rd != 0 & cnt[rd] == max & !rel[rd])).
- Register 0 never causes a stall, as a source or as a destination.
- Posedge update, when flush is 0:
  - inc = issue_fire & issue_wr & (rd != 0).
  - cnt[rd] increments by inc; cnt[wb_rd] decrements by rel.
  - Same register with both inc and rel in one cycle: net unchanged.
- Underflow: rel on a register whose cnt is 0 leaves cnt at 0 and sets err_underflow. err_underflow clears only on reset.
- flush = 1: all cnt become 0 at the next posedge.
  - Issue and writeback in the same cycle are ignored for tracking.
  - err_underflow is unaffected.
- outstanding and busy are computed from next-state counters and registered, so they reflect the counters after the edge.

## Timing
- Reset (rst_n low, asynchronous): all cnt = 0, busy = 0, outstanding = 0, err_underflow = 0.
- Reset outputs: stall = 0 and issue_fire = issue_valid, because no register is pending.
- Releasing rst_n mid-operation loses all tracking. Upstream must drain or flush the pipeline together with reset.
- stall and issue_fire have zero latency, combinational from issue_*, wb_*, and cnt.
- Counter effect of an issue becomes visible to the following cycle's stall.
- Back-to-back dependent instructions:
  - The consumer stalls until the cycle in which the producer's wb_valid is asserted.
  - issue_fire is asserted in that same cycle.
- Saturation:
  - A write to rd with cnt[rd] = 2^CW-1 stalls until a release occurs.
  - A release in the same cycle clears the stall.
- stall does not depend on flush. The issuer ignores issue_fire while flush is asserted.

## Test plan
- Reset and idle: assert rst_n low mid-cycle with cnt[5] = 2; release rst_n, keep issue_valid = 1 with rs1 = 5 -> stall = 0, busy = 0, outstanding = 0 immediately after the asynchronous assertion.
- RAW stall: issue wr rd = 3; next cycle issue rs1 = 3 -> stall = 1 for cycles 1-2; wb_valid rd = 3 in cycle 3 -> stall = 0 and issue_fire = 1 in cycle 3; outstanding returns 1 -> 0.
- Register 0: issue rd = 0 then rs1 = 0, rs2 = 0, issue_use_rs2 = 1 -> never stalls; outstanding stays 0.
- WAW saturation (CW = 2): three issues with rd = 7 -> cnt = 3; fourth issue with rd = 7 -> stall = 1; wb rd = 7 in the same cycle -> issue_fire = 1, cnt stays 3.
- Simultaneous issue and writeback of rd = 9 at cnt = 1 -> cnt stays 1, outstanding unchanged. Then wb rd = 12 at cnt = 0 -> err_underflow = 1 next cycle, sticky.
- Flush: cnt[4] = 2, cnt[6] = 1, flush = 1 with a concurrent issue of rd = 8 -> all counters 0 next cycle, busy = 0, outstanding = 0.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Issue, writeback and status signals shared between the decode/issue stage and
// the register-file hazard scoreboard.
interface regfile_scoreboard_if #(
    parameter int AW = 5,
    parameter int CW = 2
);
    logic          issue_valid;
    logic [AW-1:0] issue_rs1;
    logic [AW-1:0] issue_rs2;
    logic          issue_use_rs2;
    logic          issue_wr;
    logic [AW-1:0] issue_rd;
    logic          stall;
    logic          issue_fire;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic          flush;
    logic          busy;
    logic [AW+CW-1:0] outstanding;
    logic          err_underflow;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs2, issue_wr, issue_rd,
        output wb_valid, wb_rd, flush,
        input  stall, issue_fire, busy, outstanding, err_underflow
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs2, issue_wr, issue_rd,
        input  wb_valid, wb_rd, flush,
        output stall, issue_fire, busy, outstanding, err_underflow
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register outstanding-write counters that stall issue on RAW hazards and on
// counter saturation; writebacks release one tracked write each.
module regfile_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int CW    = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    regfile_scoreboard_if.slave  sb
);
    logic [CW-1:0]    r_cnt [NREGS];
    logic             r_busy;
    logic [AW+CW-1:0] r_outstanding;
    logic             r_err;

    logic [CW-1:0]    w_nxt  [NREGS];
    logic             w_rel  [NREGS];
    logic             w_pend [NREGS];
    logic             w_rd_sat;
    logic             w_stall;
    logic             w_fire;
    logic             w_inc;
    logic             w_uflow;
    logic [AW+CW-1:0] w_sum;

    // A last in-flight write committing this cycle no longer blocks its readers.
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            w_rel[r]  = (r != 0) && sb.wb_valid && (sb.wb_rd == AW'(r));
            w_pend[r] = (r_cnt[r] > CW'(1)) || ((r_cnt[r] == CW'(1)) && !w_rel[r]);
        end
    end

    always_comb begin
        w_rd_sat = sb.issue_wr && (sb.issue_rd != '0) &&
                   (r_cnt[sb.issue_rd] == '1) && !w_rel[sb.issue_rd];
        w_stall  = sb.issue_valid &&
                   (w_pend[sb.issue_rs1] || (sb.issue_use_rs2 && w_pend[sb.issue_rs2]) || w_rd_sat);
        w_fire   = sb.issue_valid && !w_stall;
        w_inc    = w_fire && sb.issue_wr && (sb.issue_rd != '0);
    end

    always_comb begin
        w_uflow = 1'b0;
        w_sum   = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            w_nxt[r] = r_cnt[r];
            if (r == 0 || sb.flush) begin
                w_nxt[r] = '0;
            end else begin
                if (w_rel[r] && r_cnt[r] == '0)
                    w_uflow = 1'b1;
                if (w_inc && sb.issue_rd == AW'(r)) begin
                    if (!w_rel[r])
                        w_nxt[r] = r_cnt[r] + CW'(1);
                end else if (w_rel[r] && r_cnt[r] != '0) begin
                    w_nxt[r] = r_cnt[r] - CW'(1);
                end
            end
            w_sum = w_sum + (AW+CW)'(w_nxt[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++)
                r_cnt[r] <= '0;
            r_busy        <= 1'b0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            r_cnt         <= w_nxt;
            r_busy        <= (w_sum != '0);
            r_outstanding <= w_sum;
            r_err         <= r_err | w_uflow;
        end
    end

    assign sb.stall         = w_stall;
    assign sb.issue_fire    = w_fire;
    assign sb.busy          = r_busy;
    assign sb.outstanding   = r_outstanding;
    assign sb.err_underflow = r_err;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Table-driven bench for regfile_scoreboard: combinational stall/fire checked
// mid-cycle, registered status checked through an expectation queue after the edge.
module tb_regfile_scoreboard;
    localparam int AW = 5;
    localparam int CW = 2;

    logic clk;
    logic rst_n;

    regfile_scoreboard_if #(.AW(AW), .CW(CW)) bus ();

    regfile_scoreboard #(.NREGS(32), .AW(AW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (bus)
    );

    typedef struct {
        logic          iv;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          u2;
        logic          wr;
        logic [AW-1:0] rd;
        logic          wbv;
        logic [AW-1:0] wbrd;
        logic          fl;
        logic          e_stall;
        logic          e_fire;
        logic          e_busy;
        int            e_out;
        logic          e_err;
    } vec_t;

    typedef struct {
        logic busy;
        int   out;
        logic err;
        int   idx;
    } exp_t;

    vec_t vt[$];
    exp_t sbq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input int iv, input int rs1, input int rs2, input int u2,
                                input int wr, input int rd, input int wbv, input int wbrd,
                                input int fl, input int es, input int ef, input int eo,
                                input int ee);
        vec_t v;
        v.iv = 1'(iv);  v.rs1 = AW'(rs1); v.rs2 = AW'(rs2); v.u2 = 1'(u2);
        v.wr = 1'(wr);  v.rd = AW'(rd);   v.wbv = 1'(wbv);  v.wbrd = AW'(wbrd);
        v.fl = 1'(fl);  v.e_stall = 1'(es); v.e_fire = 1'(ef);
        v.e_out = eo;   v.e_busy = (eo != 0); v.e_err = 1'(ee);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.issue_valid   = v.iv;
        bus.issue_rs1     = v.rs1;
        bus.issue_rs2     = v.rs2;
        bus.issue_use_rs2 = v.u2;
        bus.issue_wr      = v.wr;
        bus.issue_rd      = v.rd;
        bus.wb_valid      = v.wbv;
        bus.wb_rd         = v.wbrd;
        bus.flush         = v.fl;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        drive(v);
        #2;
        chk($sformatf("v%0d stall", idx), int'(bus.stall), int'(v.e_stall));
        chk($sformatf("v%0d fire", idx), int'(bus.issue_fire), int'(v.e_fire));
        sbq.push_back('{busy: v.e_busy, out: v.e_out, err: v.e_err, idx: idx});
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk($sformatf("v%0d queue", idx), 0, 1);
        end else begin
            e = sbq.pop_front();
            chk($sformatf("v%0d busy", e.idx), int'(bus.busy), int'(e.busy));
            chk($sformatf("v%0d outstanding", e.idx), int'(bus.outstanding), e.out);
            chk($sformatf("v%0d err", e.idx), int'(bus.err_underflow), int'(e.err));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(mk(1,5,0,0,0,0, 0,0,0, 0,0, 0,0));
        #3;
        chk("rst stall", int'(bus.stall), 0);
        chk("rst fire", int'(bus.issue_fire), 1);
        chk("rst busy", int'(bus.busy), 0);
        chk("rst outstanding", int'(bus.outstanding), 0);
        chk("rst err", int'(bus.err_underflow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // cnt[5] = 2, then asynchronous reset mid-cycle while reading r5
        run_vec(mk(1,0,0,0,1,5, 0,0,0, 0,1, 1,0), 100);
        run_vec(mk(1,0,0,0,1,5, 0,0,0, 0,1, 2,0), 101);
        @(negedge clk);
        drive(mk(1,5,0,0,0,0, 0,0,0, 0,0, 0,0));
        #1;
        chk("pre-rst stall", int'(bus.stall), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async stall", int'(bus.stall), 0);
        chk("async fire", int'(bus.issue_fire), 1);
        chk("async busy", int'(bus.busy), 0);
        chk("async outstanding", int'(bus.outstanding), 0);
        @(negedge clk);
        rst_n = 1'b1;

        //              iv rs1 rs2 u2 wr rd  wbv wbrd fl  st fi  out err
        vt.push_back(mk(1, 0,  0, 0, 1, 3,  0, 0,  0,  0, 1,  1, 0));
        vt.push_back(mk(1, 3,  0, 0, 0, 0,  0, 0,  0,  1, 0,  1, 0));
        vt.push_back(mk(1, 3,  0, 0, 0, 0,  0, 0,  0,  1, 0,  1, 0));
        vt.push_back(mk(1, 3,  0, 0, 0, 0,  1, 3,  0,  0, 1,  0, 0));
        vt.push_back(mk(1, 0,  0, 0, 1, 0,  0, 0,  0,  0, 1,  0, 0));
        vt.push_back(mk(1, 0,  0, 1, 1, 0,  0, 0,  0,  0, 1,  0, 0));
        vt.push_back(mk(1, 0,  0, 0, 1, 7,  0, 0,  0,  0, 1,  1, 0));
        vt.push_back(mk(1, 0,  0, 0, 1, 7,  0, 0,  0,  0, 1,  2, 0));
        vt.push_back(mk(1, 0,  0, 0, 1, 7,  0, 0,  0,  0, 1,  3, 0));
        vt.push_back(mk(1, 0,  0, 0, 1, 7,  0, 0,  0,  1, 0,  3, 0));
        vt.push_back(mk(1, 0,  0, 0, 1, 7,  1, 7,  0,  0, 1,  3, 0));
        vt.push_back(mk(1, 0,  7, 1, 0, 0,  0, 0,  0,  1, 0,  3, 0));
        vt.push_back(mk(1, 0,  7, 0, 0, 0,  0, 0,  0,  0, 1,  3, 0));
        vt.push_back(mk(0, 0,  0, 0, 0, 0,  1, 7,  0,  0, 0,  2, 0));
        vt.push_back(mk(0, 0,  0, 0, 0, 0,  1, 7,  0,  0, 0,  1, 0));
        vt.push_back(mk(1, 7,  0, 0, 0, 0,  1, 7,  0,  0, 1,  0, 0));
        vt.push_back(mk(1, 0,  0, 0, 1, 9,  0, 0,  0,  0, 1,  1, 0));
        vt.push_back(mk(1, 0,  0, 0, 1, 9,  1, 9,  0,  0, 1,  1, 0));
        vt.push_back(mk(0, 0,  0, 0, 0, 0,  1, 9,  0,  0, 0,  0, 0));
        vt.push_back(mk(0, 0,  0, 0, 0, 0,  1, 12, 0,  0, 0,  0, 1));
        vt.push_back(mk(0, 0,  0, 0, 0, 0,  0, 0,  0,  0, 0,  0, 1));
        vt.push_back(mk(1, 0,  0, 0, 1, 4,  0, 0,  0,  0, 1,  1, 1));
        vt.push_back(mk(1, 0,  0, 0, 1, 4,  0, 0,  0,  0, 1,  2, 1));
        vt.push_back(mk(1, 0,  0, 0, 1, 6,  0, 0,  0,  0, 1,  3, 1));
        vt.push_back(mk(1, 0,  0, 0, 1, 8,  0, 0,  1,  0, 1,  0, 1));
        vt.push_back(mk(1, 8,  0, 0, 0, 0,  0, 0,  0,  0, 1,  0, 1));
        vt.push_back(mk(1, 4,  6, 1, 0, 0,  0, 0,  0,  0, 1,  0, 1));

        for (int i = 0; i < vt.size(); i++)
            run_vec(vt[i], i);

        // Sticky error is cleared only by reset
        @(negedge clk);
        drive(mk(0,0,0,0,0,0, 0,0,0, 0,0, 0,0));
        rst_n = 1'b0;
        #1;
        chk("final rst err", int'(bus.err_underflow), 0);
        chk("final rst outstanding", int'(bus.outstanding), 0);
        @(negedge clk);
        rst_n = 1'b1;

        chk("queue drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
